// File: rtl/matrix_result_serializer.sv
// matrix_result_serializer
//   Snapshots the 3x3 multiplier result on each rising edge of `done` and
//   streams it as a byte frame over a valid/ready handshake:
//     SOF_BYTE, c0 .. c(N_ELEM-1) [, checksum]
//   Build option: define SERIALIZER_CHECKSUM_EN to append a mod-2^DATA_W
//   sum of the data bytes as the last byte of every frame.
module matrix_result_serializer #(
   parameter int                DATA_W   = 8,
   parameter int                N_ELEM   = 9,
   parameter logic [DATA_W-1:0] SOF_BYTE = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_ELEM*DATA_W-1:0] c_flat,
   input  logic                     done,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overrun
);

   localparam int               IDX_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
`ifdef SERIALIZER_CHECKSUM_EN
      S_DATA = 2'd2,
      S_CSUM = 2'd3
`else
      S_DATA = 2'd2
`endif
   } state_t;

   state_t            state_q, state_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] snap_q [N_ELEM];
   logic [DATA_W-1:0] snap_d [N_ELEM];
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              frame_done_q, frame_done_d;
   logic              overrun_q, overrun_d;
`ifdef SERIALIZER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   logic              start;
   logic              accept;
   logic              last_elem;
   logic              final_accept;
   logic [DATA_W-1:0] cur_elem;

   assign start     = done & ~done_q;
   assign accept    = tx_valid & tx_ready;
   assign last_elem = (idx_q == LAST_IDX);
   assign cur_elem  = snap_q[idx_q];

   // State and datapath registers; reset abandons any frame in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         done_q       <= 1'b0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         for (int i = 0; i < N_ELEM; i++) snap_q[i] <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         done_q       <= done_d;
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
         for (int i = 0; i < N_ELEM; i++) snap_q[i] <= snap_d[i];
`ifdef SERIALIZER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   // Next-state: IDLE -> HDR -> DATA -> [CSUM] -> IDLE, advancing on each accepted byte
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start)  state_d = S_HDR;
         S_HDR:  if (accept) state_d = S_DATA;
         S_DATA: begin
            if (accept && last_elem) begin
`ifdef SERIALIZER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_IDLE;
`endif
            end
         end
`ifdef SERIALIZER_CHECKSUM_EN
         S_CSUM: if (accept) state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: snapshot capture on start, index/checksum advance per data byte, status flags
   always_comb begin
      done_d = done;
      idx_d  = idx_q;
      for (int i = 0; i < N_ELEM; i++) snap_d[i] = snap_q[i];
`ifdef SERIALIZER_CHECKSUM_EN
      sum_d  = sum_q;
`endif

      if (state_q == S_IDLE && start) begin
         for (int i = 0; i < N_ELEM; i++) snap_d[i] = c_flat[i*DATA_W +: DATA_W];
         idx_d = '0;
`ifdef SERIALIZER_CHECKSUM_EN
         sum_d = '0;
`endif
      end else if (state_q == S_DATA && accept) begin
         // Wrap the index at the end so it never addresses past the snapshot
         idx_d = last_elem ? '0 : idx_q + IDX_W'(1);
`ifdef SERIALIZER_CHECKSUM_EN
         sum_d = sum_q + cur_elem;
`endif
      end

`ifdef SERIALIZER_CHECKSUM_EN
      final_accept = accept && (state_q == S_CSUM);
`else
      final_accept = accept && (state_q == S_DATA) && last_elem;
`endif
      frame_done_d = final_accept;
      // Any start seen outside IDLE (including the final-accept cycle) is dropped and flagged
      overrun_d    = overrun_q | (start & (state_q != S_IDLE));
   end

   // Outputs: valid in every non-idle state, byte selected by state
   always_comb begin
      tx_valid   = (state_q != S_IDLE);
      busy       = (state_q != S_IDLE);
      frame_done = frame_done_q;
      overrun    = overrun_q;
      tx_data    = '0;
      case (state_q)
         S_HDR:  tx_data = SOF_BYTE;
         S_DATA: tx_data = cur_elem;
`ifdef SERIALIZER_CHECKSUM_EN
         S_CSUM: tx_data = sum_q;
`endif
         default: tx_data = '0;
      endcase
   end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Testbench for matrix_result_serializer: random result matrices and random
// transmitter back-pressure, checked against a frame model built from the
// byte-order and checksum rules.
module tb_matrix_result_serializer;

   localparam int         DATA_W = 8;
   localparam int         N_ELEM = 9;
   localparam logic [7:0] SOF    = 8'hA5;
`ifdef SERIALIZER_CHECKSUM_EN
   localparam int         FL     = N_ELEM + 2;
`else
   localparam int         FL     = N_ELEM + 1;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     done = 1'b0;
   logic                     tx_ready = 1'b0;
   logic [N_ELEM*DATA_W-1:0] c_flat = '0;
   logic [DATA_W-1:0]        tx_data;
   logic                     tx_valid;
   logic                     busy;
   logic                     frame_done;
   logic                     overrun;

   matrix_result_serializer #(
      .DATA_W(DATA_W), .N_ELEM(N_ELEM), .SOF_BYTE(SOF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .c_flat(c_flat), .done(done),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] cur_c [N_ELEM];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         cyc, bubbles, stall_viol, fd_seen, bad;
   bit         timed_out;

   // Reference frame: header, elements in index order, optional byte-wide sum
   task automatic build_expected();
      int sum;
      sum = 0;
      exp_q.delete();
      exp_q.push_back(SOF);
      for (int i = 0; i < N_ELEM; i++) begin
         exp_q.push_back(cur_c[i]);
         sum = sum + int'(cur_c[i]);
      end
`ifdef SERIALIZER_CHECKSUM_EN
      exp_q.push_back(8'(sum % 256));
`endif
   endtask

   task automatic randomize_c();
      for (int i = 0; i < N_ELEM; i++) cur_c[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic drive_c();
      for (int i = 0; i < N_ELEM; i++) c_flat[i*DATA_W +: DATA_W] = cur_c[i];
   endtask

   // Guarantee a low phase, then raise done with the current matrix applied
   task automatic start_frame();
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      drive_c();
      done = 1'b1;
      build_expected();
   endtask

   // Collect accepted bytes. ready_mode 0: always ready, 1: 0/1 alternating, 2: random.
   // retrig_at >= 0 raises done again while that many bytes have been accepted.
   // Stops after nbytes accepted or after a cycle budget (timed_out).
   task automatic collect(input int ready_mode, input int retrig_at, input bit hold_done,
                          input int nbytes);
      logic [95:0] r96;
      bit          prev_stall;
      logic [7:0]  prev_data;
      got_q.delete();
      cyc = 0; bubbles = 0; stall_viol = 0; fd_seen = 0; timed_out = 1'b1;
      prev_stall = 1'b0; prev_data = '0;
      for (int it = 0; it < 300; it++) begin
         @(negedge clk);
         if (hold_done)                                    done = 1'b1;
         else if (retrig_at >= 0 && got_q.size() == retrig_at) done = 1'b1;
         else                                              done = 1'b0;
         r96 = {$urandom(), $urandom(), $urandom()};
         c_flat = r96[N_ELEM*DATA_W-1:0];
         case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (it % 2 == 1);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (!tx_valid) bubbles++;
         if (prev_stall && tx_data !== prev_data) stall_viol++;
         if (frame_done) fd_seen++;
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         cyc = it + 1;
         if (got_q.size() == nbytes) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      done  = 1'b0;
      #12;
      n_tests++;
      if ({tx_valid, busy, frame_done, overrun} !== 4'b0 || tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b busy=%b fd=%b ovr=%b data=%h, want all 0",
                  tx_valid, busy, frame_done, overrun, tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: valid=%b busy=%b, want 0 0", tx_valid, busy);
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < N_ELEM; i++) cur_c[i] = 8'(i + 1);
      start_frame();
      collect(0, -1, 1'b0, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL basic_frame: got %0d bytes (first bad idx %0d), want %0d bytes", got_q.size(), bad, FL);
      end
      n_tests++;
      if (cyc != FL || bubbles != 0) begin
         n_fail++;
         $display("FAIL basic_timing: %0d cycles with %0d bubbles, want %0d cycles 0 bubbles", cyc, bubbles, FL);
      end
      @(negedge clk); #1;
      n_tests++;
      if (frame_done !== 1'b1 || busy !== 1'b0 || fd_seen != 0) begin
         n_fail++;
         $display("FAIL basic_frame_done: fd=%b busy=%b early_fd=%0d, want 1 0 0", frame_done, busy, fd_seen);
      end
      @(negedge clk); #1;
      n_tests++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_fd_width: fd=%b on second cycle, want 0", frame_done);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < N_ELEM; i++) cur_c[i] = 8'(i + 1);
      start_frame();
      collect(1, -1, 1'b0, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL stall_frame: got %0d bytes (first bad idx %0d), want %0d", got_q.size(), bad, FL);
      end
      n_tests++;
      if (cyc != 2 * FL || stall_viol != 0 || bubbles != 0) begin
         n_fail++;
         $display("FAIL stall_timing: cycles=%0d unstable=%0d bubbles=%0d, want %0d 0 0",
                  cyc, stall_viol, bubbles, 2 * FL);
      end
      @(negedge clk); #1;
      n_tests++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_frame_done: fd=%b busy=%b, want 1 0", frame_done, busy);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 5; f++) begin
         randomize_c();
         start_frame();
         collect(2, -1, 1'b0, FL);
         n_tests++;
         bad = -1;
         for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
         if (timed_out || got_q.size() != FL || bad >= 0 || stall_viol != 0 || bubbles != 0) begin
            n_fail++;
            $display("FAIL random_frame%0d: bytes=%0d bad_idx=%0d unstable=%0d bubbles=%0d, want %0d -1 0 0",
                     f, got_q.size(), bad, stall_viol, bubbles, FL);
         end
         @(negedge clk); #1;
         n_tests++;
         if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_frame_done%0d: fd=%b busy=%b, want 1 0", f, frame_done, busy);
         end
      end
   endtask

   task automatic test_hold_done();
      int extra_valid;
      randomize_c();
      start_frame();
      collect(0, -1, 1'b1, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL hold_frame: bytes=%0d bad_idx=%0d, want %0d -1", got_q.size(), bad, FL);
      end
      extra_valid = 0;
      for (int i = cyc; i < 50; i++) begin
         @(negedge clk);
         done = 1'b1;
         #1;
         if (tx_valid) extra_valid++;
      end
      n_tests++;
      if (extra_valid != 0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_single_frame: extra valid cycles=%0d overrun=%b, want 0 0", extra_valid, overrun);
      end
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic test_overrun_mid();
      randomize_c();
      start_frame();
      collect(2, 3, 1'b0, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL overrun_mid_frame: bytes=%0d bad_idx=%0d, want %0d -1", got_q.size(), bad, FL);
      end
      repeat (4) @(negedge clk);
      #1;
      n_tests++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_mid_flag: overrun=%b busy=%b, want 1 0", overrun, busy);
      end
   endtask

   task automatic test_reset_mid();
      randomize_c();
      start_frame();
      collect(0, -1, 1'b0, 4);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({tx_valid, busy, frame_done, overrun} !== 4'b0 || tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_async: valid=%b busy=%b fd=%b ovr=%b data=%h, want all 0",
                  tx_valid, busy, frame_done, overrun, tx_data);
      end
      // done held high across release: first clock after release is a start edge
      randomize_c();
      drive_c();
      build_expected();
      done = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      collect(2, -1, 1'b0, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL reset_mid_new_frame: bytes=%0d bad_idx=%0d, want %0d -1", got_q.size(), bad, FL);
      end
      @(negedge clk); #1;
      n_tests++;
      if (frame_done !== 1'b1 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_done: fd=%b overrun=%b, want 1 0", frame_done, overrun);
      end
   endtask

   task automatic test_overrun_final();
      randomize_c();
      start_frame();
      collect(0, FL - 1, 1'b0, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL final_overrun_frame: bytes=%0d bad_idx=%0d, want %0d -1", got_q.size(), bad, FL);
      end
      @(negedge clk); #1;
      n_tests++;
      if (busy !== 1'b0 || overrun !== 1'b1 || frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL final_overrun_flag: busy=%b overrun=%b fd=%b, want 0 1 1", busy, overrun, frame_done);
      end
      done = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL final_overrun_dropped: valid=%b, want 0", tx_valid);
      end
   endtask

   task automatic test_checksum_wrap();
      for (int i = 0; i < N_ELEM; i++) cur_c[i] = 8'hFF;
      start_frame();
      collect(0, -1, 1'b0, FL);
      n_tests++;
      bad = -1;
      for (int i = 0; i < FL && i < got_q.size(); i++) if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
      if (timed_out || got_q.size() != FL || bad >= 0) begin
         n_fail++;
         $display("FAIL wrap_frame: bytes=%0d bad_idx=%0d, want %0d -1", got_q.size(), bad, FL);
      end
`ifdef SERIALIZER_CHECKSUM_EN
      n_tests++;
      if (got_q.size() != FL || got_q[FL-1] !== 8'hF7) begin
         n_fail++;
         $display("FAIL wrap_checksum: last byte=%h (bytes=%0d), want f7",
                  (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'h00, got_q.size());
      end
`endif
      @(negedge clk); #1;
      n_tests++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_frame_done: fd=%b busy=%b, want 1 0", frame_done, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_random();
      test_hold_done();
      test_overrun_mid();
      test_reset_mid();
      test_overrun_final();
      test_checksum_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
